cnn_job_sched: RTL
==================

CNN_JOB_SCHED -- requirements
Module: cnn_job_sched

Interface
REQ-001 SHALL have parameter W_SIZE, default 12, pixel width/height field width.
REQ-002 SHALL have parameter W_DELAY, default 12, sync-delay field width.
REQ-003 SHALL have parameter W_FRAME_SIZE, default 2*W_SIZE+1, frame pixel-count width.
REQ-004 SHALL have parameter W_TMO, default 24, watchdog counter width.
REQ-005 SHALL have parameter W_CFG, default 1+2*W_SIZE+2*W_DELAY; cfg packing {is_conv3x3, width, height, start_up_delay, hsync_delay}, MSB first.
REQ-006 SHALL use one clock and an asynchronous, active-high reset; ports: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-007 SHALL have ports i_req0 and i_req1  in  1  job request from requesters 0 and 1; held high until granted.
REQ-008 SHALL have ports i_cfg0 and i_cfg1  in  W_CFG  job config, valid while the matching req is high.
REQ-009 SHALL have ports o_gnt0 and o_gnt1  out  1  one-cycle pulse: cfg captured this cycle.
REQ-010 SHALL have ports o_done0 and o_done1  out  1  one-cycle job-complete pulse to the owning requester.
REQ-011 SHALL have port i_tmo_limit  in  W_TMO  watchdog limit in cycles; 0 disables the watchdog.
REQ-012 SHALL have port i_err_clr  in  1  clears the error state.
REQ-013 SHALL have ports o_busy  out  1  job in flight; o_err  out  1  sticky error flag; o_err_code  out  2  error cause: 1 zero size, 2 timeout.
REQ-014 SHALL have engine-side outputs q_is_conv3x3 (1), q_width, q_height (W_SIZE), q_start_up_delay, q_hsync_delay (W_DELAY), q_frame_size (W_FRAME_SIZE), and q_start (1), a one-cycle start pulse.
REQ-015 SHALL have engine-side inputs i_ctrl_data_run (1), i_end_frame (1), i_pix_idx (4).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, START, RUN, DONE, ERR.
REQ-017 IDLE: if any req is high, SHALL grant exactly one, pulse its gnt, capture its cfg, record the owner, and go to LOAD.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, grant the one not served last; the last-served pointer resets to 1, so req0 wins first.
REQ-019 LOAD: SHALL register q_frame_size = width*height (zero-extended to W_FRAME_SIZE) and go to START; if width==0 or height==0, SHALL go to DONE with o_err_code=1 and no q_start.
REQ-020 START: SHALL assert q_start for exactly one cycle, clear the watchdog, and go to RUN.
REQ-021 RUN: frame_done = i_ctrl_data_run & i_end_frame & (!q_is_conv3x3 | i_pix_idx==8); on frame_done SHALL go to DONE.
REQ-022 RUN: the watchdog SHALL increment every cycle; when it equals a nonzero i_tmo_limit without frame_done, the FSM SHALL set o_err=1, o_err_code=2, and go to ERR.
REQ-023 If frame_done and the timeout occur in the same cycle, frame_done SHALL win.
REQ-024 DONE: SHALL pulse the owner's done for one cycle, set o_err=1 if the job was zero-size, and return to IDLE; the next grant is earliest the cycle after DONE.
REQ-025 ERR: SHALL issue no grants and no q_start, and pulse the owner's done once on entry; on i_err_clr, SHALL clear o_err and o_err_code and go to IDLE.
REQ-026 i_err_clr in any state other than ERR SHALL clear o_err and o_err_code only.
REQ-027 All q_* config outputs SHALL be stable from LOAD until the next grant.
REQ-028 o_busy SHALL be 1 in LOAD, START, RUN, and DONE; 0 in IDLE and ERR.
REQ-029 A requester dropping req before grant SHALL forfeit the request without error.

Reset
REQ-030 rst SHALL drive every output and register to 0, the FSM to IDLE, and the last-served pointer to 1, asynchronously.
REQ-031 rst asserted mid-job SHALL abandon the job with no done pulse; after release, no q_start until a new grant.

Structure
REQ-032 State encodings, the cfg field offsets, and the err-code constants SHALL live in the shared cnn_pkg package / header with map.v.
REQ-033 The round-robin arbiter SHALL be a sub-module, cnn_rr_arb2 (req[1:0], last pointer -> one-hot grant).

Verification
REQ-034 The bench SHALL cover: req0 with cfg {1x, 8x4, delays 3/2}, engine model -> gnt0 on the cycle after req, q_frame_size=32, one q_start, done0 one cycle after frame_done, o_busy falls.
REQ-035 The bench SHALL cover: req0 and req1 high together for 3 jobs each -> grants alternate 0,1,0,1,0,1.
REQ-036 The bench SHALL cover: conv3x3 job with i_end_frame high while pix_idx=5 -> stays RUN; at pix_idx=8 -> DONE.
REQ-037 The bench SHALL cover: width=0 job -> no q_start, done pulse, o_err=1, o_err_code=1.
REQ-038 The bench SHALL cover: i_tmo_limit=100 with the engine stalled -> ERR at cycle 100 of RUN, o_err_code=2, no grants until i_err_clr.
REQ-039 The bench SHALL cover: rst pulse during RUN -> all outputs 0, no done; a new req gets gnt normally.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN job scheduler.
// Holds the FSM state encoding, error-cause codes, default field widths and
// the bit offsets of each field inside the packed job-config word
// {is_conv3x3, width, height, start_up_delay, hsync_delay} (MSB first).
package cnn_pkg;

  localparam int unsigned W_SIZE_DEF  = 12;
  localparam int unsigned W_DELAY_DEF = 12;
  localparam int unsigned W_TMO_DEF   = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ZERO_SIZE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd2;

  // LSB offsets of the cfg fields
  function automatic int unsigned cfg_off_hsync();
    return 0;
  endfunction

  function automatic int unsigned cfg_off_start_up(input int unsigned w_delay);
    return w_delay;
  endfunction

  function automatic int unsigned cfg_off_height(input int unsigned w_delay);
    return 2 * w_delay;
  endfunction

  function automatic int unsigned cfg_off_width(input int unsigned w_size,
                                                input int unsigned w_delay);
    return 2 * w_delay + w_size;
  endfunction

  function automatic int unsigned cfg_off_conv(input int unsigned w_size,
                                               input int unsigned w_delay);
    return 2 * w_delay + 2 * w_size;
  endfunction

  function automatic int unsigned cfg_width(input int unsigned w_size,
                                            input int unsigned w_delay);
    return 1 + 2 * w_size + 2 * w_delay;
  endfunction

endpackage

// File: rtl/cnn_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports: req_i   - pending requests, bit n = requester n
//        last_i  - index of the requester served most recently
//        gnt_c_o - combinational one-hot grant (zero when nothing pending)
module cnn_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_c_o
);

  // On contention favour the requester that was not served last
  always_comb begin
    gnt_c_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_c_o = last_i ? 2'b01 : 2'b10;
    end else begin
      gnt_c_o = req_i;
    end
  end

endmodule

// File: rtl/cnn_job_sched.sv
// CNN job scheduler: arbitrates two requesters, latches the winner's job
// config for the convolution engine, starts the engine, watches for end of
// frame with an optional watchdog and reports completion / errors.
// Ports: clk, rst (async active-high)
//        i_req0/1, i_cfg0/1, o_gnt0/1, o_done0/1 - requester handshake
//        i_tmo_limit, i_err_clr, o_busy, o_err, o_err_code - control/status
//        q_* - latched job config and start pulse to the engine
//        i_ctrl_data_run, i_end_frame, i_pix_idx - engine progress
module cnn_job_sched
  import cnn_pkg::*;
#(
  parameter int unsigned W_SIZE       = W_SIZE_DEF,
  parameter int unsigned W_DELAY      = W_DELAY_DEF,
  parameter int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1,
  parameter int unsigned W_TMO        = W_TMO_DEF,
  parameter int unsigned W_CFG        = 1 + 2 * W_SIZE + 2 * W_DELAY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req0,
  input  logic                    i_req1,
  input  logic [W_CFG-1:0]        i_cfg0,
  input  logic [W_CFG-1:0]        i_cfg1,
  output logic                    o_gnt0,
  output logic                    o_gnt1,
  output logic                    o_done0,
  output logic                    o_done1,
  input  logic [W_TMO-1:0]        i_tmo_limit,
  input  logic                    i_err_clr,
  output logic                    o_busy,
  output logic                    o_err,
  output logic [1:0]              o_err_code,
  output logic                    q_is_conv3x3,
  output logic [W_SIZE-1:0]       q_width,
  output logic [W_SIZE-1:0]       q_height,
  output logic [W_DELAY-1:0]      q_start_up_delay,
  output logic [W_DELAY-1:0]      q_hsync_delay,
  output logic [W_FRAME_SIZE-1:0] q_frame_size,
  output logic                    q_start,
  input  logic                    i_ctrl_data_run,
  input  logic                    i_end_frame,
  input  logic [3:0]              i_pix_idx
);

  localparam int unsigned OFF_HSYNC = cfg_off_hsync();
  localparam int unsigned OFF_SU    = cfg_off_start_up(W_DELAY);
  localparam int unsigned OFF_H     = cfg_off_height(W_DELAY);
  localparam int unsigned OFF_W     = cfg_off_width(W_SIZE, W_DELAY);
  localparam int unsigned OFF_CONV  = cfg_off_conv(W_SIZE, W_DELAY);
  localparam int unsigned W_AREA    = 2 * W_SIZE;

  state_e                  state_q;
  logic                    owner_q;
  logic                    last_q;
  logic [1:0]              gnt_q;
  logic [1:0]              done_q;
  logic                    busy_q;
  logic                    err_q;
  logic [1:0]              err_code_q;
  logic                    conv_q;
  logic [W_SIZE-1:0]       width_q;
  logic [W_SIZE-1:0]       height_q;
  logic [W_DELAY-1:0]      su_delay_q;
  logic [W_DELAY-1:0]      hs_delay_q;
  logic [W_FRAME_SIZE-1:0] frame_size_q;
  logic                    start_q;
  logic [W_TMO-1:0]        wdog_q;

  logic [1:0]              req_c;
  logic [1:0]              gnt_c;
  logic [W_CFG-1:0]        cfg_sel_c;
  logic                    frame_done_c;
  logic                    zero_size_c;
  logic [W_TMO-1:0]        wdog_inc_c;
  logic [W_AREA-1:0]       area_c;
  logic [1:0]              owner_done_c;

  assign req_c = {i_req1, i_req0};

  cnn_rr_arb2 u_arb (
    .req_i   (req_c),
    .last_i  (last_q),
    .gnt_c_o (gnt_c)
  );

  assign cfg_sel_c    = gnt_c[1] ? i_cfg1 : i_cfg0;
  // A 3x3 conv frame only ends once the last of its nine taps is processed
  assign frame_done_c = i_ctrl_data_run & i_end_frame &
                        (~conv_q | (i_pix_idx == 4'd8));
  assign zero_size_c  = (width_q == '0) || (height_q == '0);
  assign wdog_inc_c   = wdog_q + W_TMO'(1);
  assign area_c       = W_AREA'(width_q) * W_AREA'(height_q);
  assign owner_done_c = owner_q ? 2'b10 : 2'b01;

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      conv_q       <= 1'b0;
      width_q      <= '0;
      height_q     <= '0;
      su_delay_q   <= '0;
      hs_delay_q   <= '0;
      frame_size_q <= '0;
      start_q      <= 1'b0;
      wdog_q       <= '0;
    end else begin
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      start_q <= 1'b0;
      // Error clear is honoured in every state; ERR additionally exits below
      if (i_err_clr) begin
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (|req_c) begin
            gnt_q      <= gnt_c;
            owner_q    <= gnt_c[1];
            last_q     <= gnt_c[1];
            conv_q     <= cfg_sel_c[OFF_CONV];
            width_q    <= cfg_sel_c[OFF_W +: W_SIZE];
            height_q   <= cfg_sel_c[OFF_H +: W_SIZE];
            su_delay_q <= cfg_sel_c[OFF_SU +: W_DELAY];
            hs_delay_q <= cfg_sel_c[OFF_HSYNC +: W_DELAY];
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          frame_size_q <= W_FRAME_SIZE'(area_c);
          if (zero_size_c) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_ZERO_SIZE;
            done_q     <= owner_done_c;
            state_q    <= ST_DONE;
          end else begin
            start_q <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          wdog_q  <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (frame_done_c) begin
            done_q  <= owner_done_c;
            state_q <= ST_DONE;
          end else if ((i_tmo_limit != '0) && (wdog_inc_c == i_tmo_limit)) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            done_q     <= owner_done_c;
            busy_q     <= 1'b0;
            state_q    <= ST_ERR;
          end else begin
            wdog_q <= wdog_inc_c;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          if (i_err_clr) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt0           = gnt_q[0];
  assign o_gnt1           = gnt_q[1];
  assign o_done0          = done_q[0];
  assign o_done1          = done_q[1];
  assign o_busy           = busy_q;
  assign o_err            = err_q;
  assign o_err_code       = err_code_q;
  assign q_is_conv3x3     = conv_q;
  assign q_width          = width_q;
  assign q_height         = height_q;
  assign q_start_up_delay = su_delay_q;
  assign q_hsync_delay    = hs_delay_q;
  assign q_frame_size     = frame_size_q;
  assign q_start          = start_q;

endmodule
